// File: rtl/mem_access.sv
// MEM stage: load/store over a req/ack data bus with stall, lane select, load extension and bus watchdog.
// Optional MEM_ALIGN_CHECK_EN raises misaligned load/store exceptions without touching the bus.
module mem_access #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd_i,
  input  logic        mem_wreg_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [7:0]  mem_aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_reg2_i,
  input  logic [31:0] mem_pc_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stall_req_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic        exc_valid_o,
  output logic [1:0]  exc_code_o,
  output logic [31:0] exc_pc_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    off_q, off_d;
  logic [1:0]    size_q, size_d;
  logic          sext_q, sext_d;
  logic          load_q, load_d;
  logic          timeout_q, timeout_d;

  logic        is_load, is_store, is_mem, sext_in, misalign;
  logic [1:0]  size_in;
  logic [3:0]  lane_sel;
  logic [31:0] store_data, load_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size_in  = SZ_WORD;
    sext_in  = 1'b0;
    unique case (mem_aluop_i)
      EXE_LB_OP:  begin is_load = 1'b1;  size_in = SZ_BYTE; sext_in = 1'b1; end
      EXE_LBU_OP: begin is_load = 1'b1;  size_in = SZ_BYTE; end
      EXE_LH_OP:  begin is_load = 1'b1;  size_in = SZ_HALF; sext_in = 1'b1; end
      EXE_LHU_OP: begin is_load = 1'b1;  size_in = SZ_HALF; end
      EXE_LW_OP:  is_load = 1'b1;
      EXE_SB_OP:  begin is_store = 1'b1; size_in = SZ_BYTE; end
      EXE_SH_OP:  begin is_store = 1'b1; size_in = SZ_HALF; end
      EXE_SW_OP:  is_store = 1'b1;
      default: ;
    endcase
    is_mem = is_load | is_store;
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = is_mem && (((size_in == SZ_HALF) && mem_addr_i[0]) ||
                               ((size_in == SZ_WORD) && (mem_addr_i[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    lane_sel   = 4'b1111;
    store_data = mem_reg2_i;
    if (size_in == SZ_BYTE) begin
      lane_sel   = 4'b0001 << mem_addr_i[1:0];
      store_data = {4{mem_reg2_i[7:0]}};
    end else if (size_in == SZ_HALF) begin
      lane_sel   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      store_data = {2{mem_reg2_i[15:0]}};
    end
  end

  // Lane offsets come from the latched address, so the inputs only need to hold for wd/pc.
  always_comb begin
    ld_byte  = rdata_q[8*off_q +: 8];
    ld_half  = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_ext = rdata_q;
    if (size_q == SZ_BYTE)
      load_ext = {{24{sext_q & ld_byte[7]}}, ld_byte};
    else if (size_q == SZ_HALF)
      load_ext = {{16{sext_q & ld_half[15]}}, ld_half};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    off_d     = off_q;
    size_d    = size_q;
    sext_d    = sext_q;
    load_d    = load_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_mem && !misalign) begin
          state_d   = S_WAIT;
          cnt_d     = '0;
          req_d     = 1'b1;
          we_d      = is_store;
          sel_d     = lane_sel;
          addr_d    = {mem_addr_i[31:2], 2'b00};
          wdata_d   = store_data;
          off_d     = mem_addr_i[1:0];
          size_d    = size_in;
          sext_d    = sext_in;
          load_d    = is_load;
          timeout_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (dbus_ack_i) begin
          rdata_d = dbus_rdata_i;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if ((MAX_WAIT > 0) && (cnt_q == CNT_LAST)) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        timeout_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      off_q     <= '0;
      size_q    <= SZ_BYTE;
      sext_q    <= 1'b0;
      load_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      off_q     <= off_d;
      size_q    <= size_d;
      sext_q    <= sext_d;
      load_q    <= load_d;
      timeout_q <= timeout_d;
    end
  end

  assign dbus_req_o   = req_q;
  assign dbus_we_o    = we_q;
  assign dbus_sel_o   = sel_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_wdata_o = wdata_q;

  always_comb begin
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    stall_req_o = 1'b0;
    exc_valid_o = 1'b0;
    exc_code_o  = 2'b00;
    exc_pc_o    = '0;
    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          wd_o = mem_wd_i;
          if (misalign) begin
            exc_valid_o = 1'b1;
            exc_code_o  = is_load ? 2'b01 : 2'b10;
            exc_pc_o    = mem_pc_i;
          end else if (is_mem) begin
            stall_req_o = 1'b1;
          end else begin
            wreg_o  = mem_wreg_i;
            wdata_o = mem_wdata_i;
          end
        end
        S_WAIT: stall_req_o = 1'b1;
        S_DONE: begin
          wd_o = mem_wd_i;
          if (timeout_q) begin
            exc_valid_o = 1'b1;
            exc_code_o  = 2'b11;
            exc_pc_o    = mem_pc_i;
          end else if (load_q) begin
            wreg_o  = 1'b1;
            wdata_o = load_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
